// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data (load/store) requester. One transaction is in flight
// at a time: IDLE (grant) -> ACCESS (MEM_LATENCY cycles) -> RESPOND (1 cycle).
// Optional build macro ARBITER_ROUND_ROBIN_EN: on simultaneous requests,
// alternate between requesters; otherwise data always wins.
module memory_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic        fetch_grant,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_value,
  output logic        data_grant,
  output logic        data_valid,
  output logic [31:0] data_read_value,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_value,
  input  logic [31:0] mem_read_value,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;   // last winner: 0 = fetch, 1 = data
  logic        win_q, win_d;     // current winner: 0 = fetch, 1 = data
  logic        wr_q, wr_d;       // current transaction is a data store
  logic [31:0] addr_q, addr_d;
  logic [31:0] wval_q, wval_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pick_data;

  // Winner selection among concurrent requests
  always_comb begin
`ifdef ARBITER_ROUND_ROBIN_EN
    if (fetch_req && data_req) pick_data = ~last_q;
    else                       pick_data = data_req;
`else
    // last_winner is still tracked but has no effect on the decision
    pick_data = data_req | (data_req & last_q);
`endif
  end

  // Next-state, latch updates and grant generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wval_d      = wval_q;
    rdata_d     = rdata_q;
    fetch_grant = 1'b0;
    data_grant  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!reset && (fetch_req || data_req)) begin
          fetch_grant = ~pick_data;
          data_grant  = pick_data;
          win_d       = pick_data;
          last_d      = pick_data;
          wr_d        = pick_data & data_write;
          addr_d      = pick_data ? data_address : fetch_address;
          if (pick_data) wval_d = data_write_value;
          cnt_d       = CNT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          rdata_d = wr_q ? 32'h0 : mem_read_value;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wval_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wval_q  <= wval_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side and response-side outputs derived from registered state
  always_comb begin
    mem_enable      = (state_q == ACCESS);
    mem_write       = (state_q == ACCESS) && wr_q;
    mem_address     = addr_q;
    mem_write_value = wval_q;
    busy            = (state_q != IDLE);
    fetch_valid     = (state_q == RESPOND) && !win_q && !reset;
    data_valid      = (state_q == RESPOND) &&  win_q && !reset;
    fetch_data      = rdata_q;
    data_read_value = rdata_q;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a response scoreboard and a
// simple behavioural memory attached to the memory port.
module tb_memory_port_arbiter;
  localparam int L = 2;
`ifdef ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_grant, fetch_valid;
  logic [31:0] fetch_address, fetch_data;
  logic        data_req, data_write, data_grant, data_valid;
  logic [31:0] data_address, data_write_value, data_read_value;
  logic        mem_enable, mem_write, busy;
  logic [31:0] mem_address, mem_write_value;
  logic [31:0] mem_read_value = 32'h0;

  memory_port_arbiter #(.MEM_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_grant(fetch_grant),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_write(data_write), .data_address(data_address),
    .data_write_value(data_write_value), .data_grant(data_grant),
    .data_valid(data_valid), .data_read_value(data_read_value),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_data;
    logic [31:0] word;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;

  function automatic logic [31:0] env_rd(logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural memory: stores land, reads are presented mid-cycle
  always @(negedge clock) begin
    if (mem_enable && mem_write) env_mem[mem_address] = mem_write_value;
    mem_read_value = mem_enable ? env_rd(mem_address) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Scoreboard hook: push on handshake, pop and compare on valid
  task automatic sample();
    exp_t e;
    #1;
    chk("one_grant", {31'h0, fetch_grant & data_grant}, 32'h0);
    if (fetch_grant) begin
      chk("fgrant_has_req", {31'h0, fetch_req}, 32'h1);
      e.is_data = 1'b0; e.word = ref_rd(fetch_address); e.gcyc = cyc;
      sb.push_back(e);
    end
    if (data_grant) begin
      chk("dgrant_has_req", {31'h0, data_req}, 32'h1);
      e.is_data = 1'b1;
      e.word = data_write ? 32'h0 : ref_rd(data_address);
      e.gcyc = cyc;
      if (data_write) ref_mem[data_address] = data_write_value;
      sb.push_back(e);
    end
    if (fetch_valid || data_valid) begin
      chk("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid_port", {31'h0, data_valid}, {31'h0, e.is_data});
        chk("valid_word", data_valid ? data_read_value : fetch_data, e.word);
        chk("latency", 32'(cyc - e.gcyc), 32'(L + 1));
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin sample(); adv(); end
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_write = 1'b0;
    adv(); adv();
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    env_mem[32'h40] = 32'h8C01_0004;
    ref_mem[32'h40] = 32'h8C01_0004;
    reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_write = 1'b0;
    fetch_address = 32'h0; data_address = 32'h0; data_write_value = 32'h0;
    adv(); adv();

    // Reset state
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_men", {31'h0, mem_enable}, 32'h0);
    chk("rst_mwr", {31'h0, mem_write}, 32'h0);
    chk("rst_maddr", mem_address, 32'h0);
    chk("rst_mwval", mem_write_value, 32'h0);
    chk("rst_fdata", fetch_data, 32'h0);
    chk("rst_ddata", data_read_value, 32'h0);
    chk("rst_valids", {30'h0, fetch_valid, data_valid}, 32'h0);
    chk("rst_grants", {30'h0, fetch_grant, data_grant}, 32'h0);
    reset = 1'b0;
    adv();

    // Fetch at 0x40
    fetch_req = 1'b1; fetch_address = 32'h40;
    sample();
    chk("f_grant", {31'h0, fetch_grant}, 32'h1);
    chk("f_busy0", {31'h0, busy}, 32'h0);
    adv(); fetch_req = 1'b0;
    for (int k = 1; k <= L; k++) begin
      sample();
      chk("f_men", {31'h0, mem_enable}, 32'h1);
      chk("f_maddr", mem_address, 32'h40);
      chk("f_mwr", {31'h0, mem_write}, 32'h0);
      chk("f_busy", {31'h0, busy}, 32'h1);
      chk("f_novalid", {31'h0, fetch_valid}, 32'h0);
      adv();
    end
    sample();
    chk("f_valid", {31'h0, fetch_valid}, 32'h1);
    chk("f_data", fetch_data, 32'h8C01_0004);
    chk("f_men_off", {31'h0, mem_enable}, 32'h0);
    adv();
    sample();
    chk("f_pulse_end", {31'h0, fetch_valid}, 32'h0);
    chk("f_idle", {31'h0, busy}, 32'h0);
    adv();

    // Store 0xDEADBEEF to 0x100
    data_req = 1'b1; data_write = 1'b1; data_address = 32'h100; data_write_value = 32'hDEAD_BEEF;
    sample();
    chk("s_grant", {31'h0, data_grant}, 32'h1);
    adv(); data_req = 1'b0; data_write = 1'b0;
    for (int k = 1; k <= L; k++) begin
      sample();
      chk("s_mwr", {31'h0, mem_write}, 32'h1);
      chk("s_maddr", mem_address, 32'h100);
      chk("s_mwval", mem_write_value, 32'hDEAD_BEEF);
      adv();
    end
    sample();
    chk("s_valid", {31'h0, data_valid}, 32'h1);
    chk("s_rdata", data_read_value, 32'h0);
    chk("s_nofetch", {31'h0, fetch_valid}, 32'h0);
    chk("s_mwr_off", {31'h0, mem_write}, 32'h0);
    adv();
    idle_cycles(1);

    // Load back from 0x100
    data_req = 1'b1; data_address = 32'h100;
    sample();
    chk("l_grant", {31'h0, data_grant}, 32'h1);
    adv(); data_req = 1'b0;
    idle_cycles(L + 2);

    // Both requesters held after reset
    do_reset();
    fetch_req = 1'b1; fetch_address = 32'h200;
    data_req = 1'b1; data_address = 32'h300;
    for (int c = 0; c < 12; c++) begin
      sample();
      chk($sformatf("arb_dg_c%0d", c), {31'h0, data_grant},
          {31'h0, (c % 4 == 0) && !(RR && c == 4)});
      chk($sformatf("arb_fg_c%0d", c), {31'h0, fetch_grant}, {31'h0, RR && c == 4});
      adv();
    end
    fetch_req = 1'b0; data_req = 1'b0;
    idle_cycles(4);

    // Reset in the second access cycle of a fetch
    do_reset();
    fetch_req = 1'b1; fetch_address = 32'h40;
    sample();
    chk("r_grant", {31'h0, fetch_grant}, 32'h1);
    adv(); fetch_req = 1'b0;
    sample(); adv();
    reset = 1'b1;
    sample(); adv();
    reset = 1'b0; sb.delete();
    sample();
    chk("r_busy", {31'h0, busy}, 32'h0);
    chk("r_men", {31'h0, mem_enable}, 32'h0);
    chk("r_novalid", {31'h0, fetch_valid}, 32'h0);
    adv();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("r_novalid_late", {31'h0, fetch_valid}, 32'h0);
      adv();
    end
    fetch_req = 1'b1; fetch_address = 32'h44;
    sample();
    chk("r_regrant", {31'h0, fetch_grant}, 32'h1);
    adv(); fetch_req = 1'b0;
    idle_cycles(L + 2);

    // Data request raised during a fetch's ACCESS waits for IDLE
    fetch_req = 1'b1; fetch_address = 32'h48;
    sample(); adv(); fetch_req = 1'b0;
    data_req = 1'b1; data_address = 32'h104;
    for (int k = 1; k <= L; k++) begin
      sample();
      chk("w_dg_access", {31'h0, data_grant}, 32'h0);
      adv();
    end
    sample();
    chk("w_fvalid", {31'h0, fetch_valid}, 32'h1);
    chk("w_dg_respond", {31'h0, data_grant}, 32'h0);
    adv();
    sample();
    chk("w_dg_idle", {31'h0, data_grant}, 32'h1);
    adv(); data_req = 1'b0;
    idle_cycles(L + 2);

    // Request dropped before grant causes no access
    fetch_req = 1'b1; fetch_address = 32'h50;
    sample(); adv(); fetch_req = 1'b0;
    data_req = 1'b1; data_address = 32'h108;
    sample(); adv();
    data_req = 1'b0;
    idle_cycles(L);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("d_no_access", {30'h0, mem_enable, busy}, 32'h0);
      adv();
    end

    // Extreme addresses pass through unaltered
    fetch_req = 1'b1; fetch_address = 32'hFFFF_FFFF;
    sample(); adv(); fetch_req = 1'b0;
    sample();
    chk("x_faddr", mem_address, 32'hFFFF_FFFF);
    adv();
    idle_cycles(L + 1);
    data_req = 1'b1; data_address = 32'hFFFF_FFFC;
    sample(); adv(); data_req = 1'b0;
    sample();
    chk("x_daddr", mem_address, 32'hFFFF_FFFC);
    adv();
    idle_cycles(L + 1);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter: MEM_LATENCY, 2, memory cycles from address presented to mem_read_value valid (legal 1..15).
REQ-002 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: fetch_req input 1 fetch request; fetch_address input 32 fetch address; fetch_grant output 1 fetch accepted; fetch_valid output 1 fetch data ready; fetch_data output 32 fetched word.
REQ-005 SHALL have ports: data_req input 1 data request; data_write input 1 store when high, load when low; data_address input 32; data_write_value input 32; data_grant output 1; data_valid output 1 load data ready or store done; data_read_value output 32.
REQ-006 SHALL have ports: mem_enable output 1; mem_write output 1; mem_address output 32; mem_write_value output 32; mem_read_value input 32; busy output 1 high in any state but IDLE.

Function
REQ-007 SHALL implement states IDLE, ACCESS, RESPOND; one transaction in flight at most.
REQ-008 In IDLE with any req high, SHALL assert exactly one grant combinationally that cycle; req&grant is the handshake; no grant outside IDLE.
REQ-009 Requester SHALL hold req and payload until grant; arbiter latches address, write flag, write value and winner on the grant edge.
REQ-010 On grant SHALL go IDLE->ACCESS, load 4-bit counter with MEM_LATENCY-1.
REQ-011 In ACCESS SHALL drive mem_enable=1, mem_address/mem_write_value from latches, mem_write=1 only for a data store; decrement counter each cycle.
REQ-012 On ACCESS cycle with counter==0 SHALL capture mem_read_value (loads/fetches) or 0 (stores) and go to RESPOND.
REQ-013 In RESPOND SHALL pulse the winner's valid for exactly one cycle with captured word on its data output, then return to IDLE.
REQ-014 Latency grant-to-valid SHALL be MEM_LATENCY+1 cycles; back-to-back throughput one transaction per MEM_LATENCY+2 cycles.
REQ-015 fetch_data/data_read_value SHALL hold last captured value between pulses; values outside valid pulses carry no meaning.
REQ-016 Outside ACCESS, mem_enable and mem_write SHALL be 0; mem_address/mem_write_value hold latched values.
REQ-017 Addresses SHALL pass unaltered, 32 bits, no alignment check or wrap.
REQ-018 Requests raised in ACCESS/RESPOND SHALL wait; a req dropped before grant SHALL cause no access.
REQ-019 Arbiter SHALL keep a last_winner bit, updated at every grant.

Reset
REQ-020 Reset SHALL force IDLE, counter 0, last_winner=fetch, all grants/valids/mem_enable/mem_write/busy 0, latched address, write value and captured data 0.
REQ-021 Reset during ACCESS or RESPOND SHALL abandon the transaction: no valid pulse, mem_enable 0 in the cycle after reset asserted.

Configuration
REQ-022 Macro ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests grant the requester that is not last_winner.
REQ-023 Macro absent: on simultaneous requests data always wins; last_winner kept but unused.

Verification (MEM_LATENCY=2)
REQ-024 fetch_req=1, fetch_address=0x40, mem returns 0x8C010004 -> fetch_grant cycle 0, mem_enable cycles 1-2 address 0x40, fetch_valid cycle 3 with fetch_data 0x8C010004.
REQ-025 data store address 0x100 value 0xDEADBEEF -> mem_write=1 cycles 1-2, data_valid cycle 3 with data_read_value 0, fetch_valid never.
REQ-026 both req held after reset -> macro defined: data, fetch, data grants at cycles 0,4,8; macro absent: data grants at 0,4,8, fetch never granted.
REQ-027 reset asserted in cycle 2 of a fetch -> no fetch_valid, busy 0 and mem_enable 0 from cycle 3, next req granted normally.
REQ-028 data_req pulsed high during ACCESS of a fetch and held -> data_grant in first IDLE cycle after fetch_valid, not before.
